fwd_scoreboard: RTL and testbench
=================================

// Module: fwd_scoreboard
// PURPOSE
//   Parametrised operand-hazard unit for the decode stage. Tracks in-flight register writes in a
//   NUM_STAGES-deep shift array (execute .. writeback) with per-entry result-latency countdown.
//   Per source operand it selects the youngest matching forward value or the register-file value,
//   and raises stall/bubble while a needed result is still outstanding.
//   Generalises fixed E/M forwarding to N stages, N sources and multi-cycle producers (mul/div/load).
// PARAMETERS
//   NUM_STAGES  3   tracked stages after decode; stage 0 = execute; must be >= MAX_LAT+1
//   NUM_SRC     3   source operands per instruction
//   REG_W       5   register address width
//   DATA_W      32  data width
//   MAX_LAT     2   largest producer latency in cycles; LAT_W = $clog2(MAX_LAT+1)
// PORTS
//   clk        in   1                  clock
//   reset      in   1                  synchronous reset, active-high
//   iss_valid  in   1                  decode holds a valid instruction
//   iss_dst    in   REG_W              destination register; 0 = no write
//   iss_lat    in   LAT_W              cycles until result is valid; 0 = ALU, 1 = load, ...
//   src_addr   in   NUM_SRC*REG_W      source register addresses
//   rf_data    in   NUM_SRC*DATA_W     register-file read data for each source
//   stage_val  in   NUM_STAGES*DATA_W  result value currently held in each tracked stage
//   hold       in   1                  downstream freeze: whole pipe holds
//   flush      in   1                  kill all in-flight entries (branch/exception)
//   src_data   out  NUM_SRC*DATA_W     resolved operand values
//   stall      out  1                  decode and fetch must hold
//   bubble     out  1                  stage 0 receives a bubble this edge
//   busy       out  1                  some valid entry has remaining latency > 0
// BEHAVIOUR
//   - Entry fields: {valid, dst, rem[LAT_W]}. Reset clears every entry (valid=0, dst=0, rem=0).
//     With the array empty: stall=0, bubble=0, busy=0, src_data=rf_data (0 for address 0).
//   - Outputs are combinational from the entry array and current inputs; state updates on posedge clk.
//   - Lookup for source s, scanning k = 0..NUM_STAGES-1 (youngest first):
//     * First entry with valid && dst==src_addr[s] && dst!=0 wins.
//       If its rem==0, src_data[s]=stage_val[k]. If its rem>0, the source is not ready.
//     * No match: src_data[s]=rf_data[s].
//     * src_addr[s]==0: src_data[s]=0 and the source is never not-ready.
//   - stall = iss_valid && (some source not ready) && !flush. bubble = stall && !hold.
//   - Countdown: on every edge, each valid entry with rem>0 decrements rem by 1. This applies under hold too.
//   - Shift, when !hold: entry k moves to k+1; the entry leaving NUM_STAGES-1 is dropped
//     (the register file has been written). Stage 0 is loaded as follows:
//     * stall: loaded with a bubble (valid=0).
//     * otherwise: valid=iss_valid && iss_dst!=0, dst=iss_dst, rem=iss_lat.
//   - hold: no shift and no issue accepted; bubble=0; countdown continues.
//   - Priority: reset > flush > hold > normal. flush clears all entries on that edge.
//     An instruction in decode with flush=1 is not captured.
//   - A new entry captured at stage 0 has rem=iss_lat.
//     ALU result (lat 0): forwardable from stage 0 the following cycle.
//     Load (lat 1): exactly one stall cycle, then forwarded from stage 1.
//   - iss_lat > MAX_LAT is illegal. The bench asserts it never occurs.
//     An entry reaching the last stage always has rem==0.
// TESTING
//   1 addu $8 (lat 0), next cycle src0=8, stage_val[0]=0x1234 -> src_data[0]=0x1234, stall=0.
//   2 lw $9 (lat 1), next cycle src1=9 -> stall=1, bubble=1 for one cycle; then src_data[1]=stage_val[1]=0xDEAD, stall=0.
//   3 stage0 and stage1 both dst=3 (rem 0), src0=3, vals 0xA/0xB -> src_data[0]=0xA (youngest wins).
//   4 producer dst=0; src0=0 with rf_data=0xFFFF_FFFF -> src_data[0]=0, stall=0.
//   5 mul $4 lat 2, dependent next -> 2 stall cycles; hold=1 during the first stall cycle
//     -> bubble=0, rem still decrements, total stall cycles stays 2.
//   6 flush during lw stall -> next cycle all entries invalid, stall=0, busy=0;
//     reset mid-operation -> same result.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: decode-stage operand forwarding and hazard stall over N tracked stages
module fwd_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC = 3,
  parameter int REG_W = 5,
  parameter int DATA_W = 32,
  parameter int MAX_LAT = 2,
  localparam int LAT_W = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iss_valid,
  input  logic [REG_W-1:0]             iss_dst,
  input  logic [LAT_W-1:0]             iss_lat,
  input  logic [NUM_SRC*REG_W-1:0]     src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]    rf_data,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_val,
  input  logic                         hold,
  input  logic                         flush,
  output logic [NUM_SRC*DATA_W-1:0]    src_data,
  output logic                         stall,
  output logic                         bubble,
  output logic                         busy
);
  logic [NUM_STAGES-1:0]            valid_q, valid_d;
  logic [NUM_STAGES-1:0][REG_W-1:0] dst_q, dst_d;
  logic [NUM_STAGES-1:0][LAT_W-1:0] rem_q, rem_d, rem_n;
  logic [NUM_SRC-1:0]               hit, not_rdy;
  logic [NUM_STAGES-1:0]            pending;

  always_comb begin
    src_data = rf_data;
    hit = '0;
    not_rdy = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (src_addr[s*REG_W +: REG_W] == '0) begin
        src_data[s*DATA_W +: DATA_W] = '0;
      end else begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (!hit[s] && valid_q[k] && dst_q[k] == src_addr[s*REG_W +: REG_W]) begin
            hit[s] = 1'b1;
            not_rdy[s] = rem_q[k] != '0;
            src_data[s*DATA_W +: DATA_W] = stage_val[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_comb begin
    rem_n = rem_q;
    pending = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      pending[k] = valid_q[k] && rem_q[k] != '0;
      rem_n[k] = pending[k] ? rem_q[k] - LAT_W'(1) : rem_q[k];
    end
  end

  assign stall = iss_valid && |not_rdy && !flush;
  assign bubble = stall && !hold;
  assign busy = |pending;

  always_comb begin
    valid_d = '0;
    dst_d = '0;
    rem_d = '0;
    if (!flush && hold) begin
      valid_d = valid_q;
      dst_d = dst_q;
      rem_d = rem_n;
    end else if (!flush) begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        dst_d[k] = dst_q[k-1];
        rem_d[k] = rem_n[k-1];
      end
      valid_d[0] = !stall && iss_valid && iss_dst != '0;
      dst_d[0] = stall ? '0 : iss_dst;
      rem_d[0] = stall ? '0 : iss_lat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
    end else begin
      valid_q <= valid_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
    end
  end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed forwarding/stall scenarios with hand-computed expectations
module tb_fwd_scoreboard;
  localparam int MAX_LAT = 2;
  logic clk = 1'b0;
  logic reset, iss_valid, hold, flush;
  logic [4:0] iss_dst;
  logic [1:0] iss_lat;
  logic [4:0] sa [3];
  logic [31:0] rd [3];
  logic [31:0] sv [3];
  logic [95:0] src_data;
  logic stall, bubble, busy;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .clk(clk),
    .reset(reset),
    .iss_valid(iss_valid),
    .iss_dst(iss_dst),
    .iss_lat(iss_lat),
    .src_addr({sa[2], sa[1], sa[0]}),
    .rf_data({rd[2], rd[1], rd[0]}),
    .stage_val({sv[2], sv[1], sv[0]}),
    .hold(hold),
    .flush(flush),
    .src_data(src_data),
    .stall(stall),
    .bubble(bubble),
    .busy(busy)
  );

  always @(posedge clk) assert (!(iss_valid && iss_lat > MAX_LAT));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] d, input logic [1:0] l);
    iss_valid = v;
    iss_dst = d;
    iss_lat = l;
  endtask

  function automatic logic [31:0] sd(input int s);
    return src_data[s*32 +: 32];
  endfunction

  initial begin
    reset = 1'b1;
    hold = 1'b0;
    flush = 1'b0;
    issue(0, 0, 0);
    sa[0] = 5'd1; sa[1] = 5'd2; sa[2] = 5'd0;
    rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33;
    sv[0] = 32'h0; sv[1] = 32'h0; sv[2] = 32'h0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_src0", sd(0), 32'h11);
    chk("rst_src1", sd(1), 32'h22);
    chk("rst_src2_zero", sd(2), 32'h0);
    chk("rst_stall", stall, 0);
    chk("rst_bubble", bubble, 0);
    chk("rst_busy", busy, 0);
    sa[0] = 0; sa[1] = 0; sa[2] = 0;
    issue(1, 8, 0);
    #1;
    chk("alu_issue_stall", stall, 0);
    step();
    issue(1, 0, 0);
    sa[0] = 8; sv[0] = 32'h1234;
    #1;
    chk("alu_fwd_src0", sd(0), 32'h1234);
    chk("alu_fwd_stall", stall, 0);
    chk("alu_fwd_busy", busy, 0);
    step();
    sa[0] = 0;
    issue(1, 9, 1);
    #1;
    chk("lw_issue_busy", busy, 0);
    step();
    issue(1, 0, 0);
    sa[1] = 9; sv[1] = 32'hDEAD;
    #1;
    chk("lw_dep_stall", stall, 1);
    chk("lw_dep_bubble", bubble, 1);
    chk("lw_dep_busy", busy, 1);
    step();
    chk("lw_fwd_stall", stall, 0);
    chk("lw_fwd_bubble", bubble, 0);
    chk("lw_fwd_src1", sd(1), 32'hDEAD);
    chk("lw_fwd_busy", busy, 0);
    step();
    sa[1] = 0;
    issue(1, 3, 0);
    step();
    step();
    issue(1, 0, 0);
    sa[0] = 3; sa[2] = 5;
    sv[0] = 32'hA; sv[1] = 32'hB; sv[2] = 32'hC;
    #1;
    chk("young_src0", sd(0), 32'hA);
    chk("young_stall", stall, 0);
    chk("nomatch_src2", sd(2), 32'h33);
    step();
    sa[0] = 0; sa[1] = 3; sa[2] = 0;
    rd[0] = 32'hFFFF_FFFF;
    #1;
    chk("zero_src0", sd(0), 32'h0);
    chk("zero_stall", stall, 0);
    chk("young_s1_src1", sd(1), 32'hB);
    issue(0, 0, 0);
    sa[1] = 0;
    step();
    step();
    step();
    chk("idle_busy", busy, 0);
    issue(1, 4, 2);
    step();
    issue(1, 0, 0);
    sa[0] = 4; sv[1] = 32'h4444;
    hold = 1'b1;
    #1;
    chk("mul_hold_stall", stall, 1);
    chk("mul_hold_bubble", bubble, 0);
    chk("mul_hold_busy", busy, 1);
    step();
    hold = 1'b0;
    #1;
    chk("mul_stall2", stall, 1);
    chk("mul_bubble2", bubble, 1);
    step();
    chk("mul_done_stall", stall, 0);
    chk("mul_fwd_src0", sd(0), 32'h4444);
    chk("mul_done_busy", busy, 0);
    step();
    sa[0] = 0;
    issue(1, 9, 1);
    step();
    issue(1, 0, 0);
    sa[1] = 9;
    #1;
    chk("flush_pre_stall", stall, 1);
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    chk("flush_bubble", bubble, 0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_post_stall", stall, 0);
    chk("flush_src1", sd(1), 32'h22);
    sa[1] = 0;
    issue(1, 9, 1);
    step();
    issue(1, 0, 0);
    sa[1] = 9;
    #1;
    chk("rst2_pre_stall", stall, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rst2_stall", stall, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_src1", sd(1), 32'h22);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
